// File: rtl/sid_rx.sv
// sid_rx: captures a frame of DEPTH non-zero ID bytes written to one bus
// address, holds it for byte-wise readout, and flags idle timeouts or
// writes arriving while a frame is held.
// Optional feature macro: SID_RX_CMP_EN -- when defined, the captured frame is
// compared against the ASCII ID "2023310655" and match_o reports the result.
// Handshake: a pop is requested by holding rd_en_i high for one cycle while
// done_o=1; the byte appears on rd_data_o with rd_valid_o=1 on the next cycle.
// rd_en_i is ignored at all other times, and there is no back-pressure.
module sid_rx #(
  parameter int          DEPTH   = 10,
  parameter logic [31:0] ADDR    = 32'h3000_0000,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        rd_en_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        match_o,
  output logic        err_o,
  output logic [3:0]  count_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [3:0]  count_q;
  logic [3:0]  rd_ptr;
  logic [7:0]  idle_q;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  wr_byte;
  logic        acc;
  logic        timeout;
  logic        pop;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        unused_data;

  assign wr_byte     = data_i[7:0];
  assign unused_data = ^data_i[31:8];
  assign acc         = we_i && (addr_i == ADDR) && (wr_byte != 8'h00);
  assign timeout     = (idle_q == TO_LAST);
  assign pop         = rd_en_i && (state == DONE) && (count_q != 4'd0);
  assign wr_en       = acc && ((state == IDLE) || (state == RECV));
  assign wr_idx      = (state == IDLE) ? 4'd0 : count_q;
  assign busy_o      = (state == RECV);
  assign count_o     = count_q;
  assign dbg_state_o = state;

  // Next-state decode; an accepted byte takes priority over a timeout.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = RECV;
      RECV: begin
        if (acc) begin
          if (count_q == LAST_IDX) state_n = DONE;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      DONE: if (pop && (count_q == 4'd1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus counters, read port and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count_q    <= 4'd0;
      rd_ptr     <= 4'd0;
      idle_q     <= 8'd0;
      rd_data_o  <= 8'd0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            count_q <= 4'd1;
            idle_q  <= 8'd0;
            rd_ptr  <= 4'd0;
          end
        end
        RECV: begin
          if (acc) begin
            count_q <= count_q + 4'd1;
            idle_q  <= 8'd0;
            if (count_q == LAST_IDX) done_o <= 1'b1;
          end else if (timeout) begin
            err_o   <= 1'b1;
            count_q <= 4'd0;
            idle_q  <= 8'd0;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
        end
        DONE: begin
          if (acc) err_o <= 1'b1;
          if (pop) begin
            rd_data_o  <= mem[rd_ptr];
            rd_valid_o <= 1'b1;
            count_q    <= count_q - 4'd1;
            rd_ptr     <= rd_ptr + 4'd1;
            if (count_q == 4'd1) begin
              done_o <= 1'b0;
              rd_ptr <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame storage; contents are not reset, only written while collecting.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_byte;
  end

`ifdef SID_RX_CMP_EN
  logic match_q;

  function automatic logic [7:0] id_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0: b = 8'h32;
      4'd1: b = 8'h30;
      4'd2: b = 8'h32;
      4'd3: b = 8'h33;
      4'd4: b = 8'h33;
      4'd5: b = 8'h31;
      4'd6: b = 8'h30;
      4'd7: b = 8'h36;
      4'd8: b = 8'h35;
      4'd9: b = 8'h35;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Running match flag: restarted by the first byte, ANDed with each later one.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if ((state == IDLE) && acc) begin
      match_q <= (wr_byte == id_byte(4'd0));
    end else if ((state == RECV) && acc) begin
      match_q <= match_q && (wr_byte == id_byte(count_q));
    end else if (pop && (count_q == 4'd1)) begin
      match_q <= 1'b0;
    end
  end

  assign match_o = match_q && (state == DONE);
`else
  assign match_o = 1'b0;
`endif

endmodule

// File: tb/tb_sid_rx.sv
// Bench for sid_rx: cycle-level stimulus against a queue-based model of the
// frame buffer; read-back bytes and error pulses are checked by a monitor.
module tb_sid_rx;

  localparam int          DEPTH   = 10;
  localparam logic [31:0] ADDR    = 32'h3000_0000;
  localparam int          TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        rd_en_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        match_o;
  logic        err_o;
  logic [3:0]  count_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [7:0] exp_q[$];
  int         err_q[$];

  logic [7:0] m_frame[$];
  bit         m_full;
  int         m_idle;
  bit         m_match;
  logic [7:0] id_str [10] = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33,
                              8'h31, 8'h30, 8'h36, 8'h35, 8'h35};

  sid_rx #(.DEPTH(DEPTH), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .match_o    (match_o),
    .err_o      (err_o),
    .count_o    (count_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at edge %0d", name, got, exp, edge_n);
    end
  endtask

  function automatic bit frame_is_id();
`ifdef SID_RX_CMP_EN
    bit ok;
    ok = 1'b1;
    foreach (m_frame[i]) if (m_frame[i] != id_str[i]) ok = 1'b0;
    return ok;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_status();
    chk("count", 32'(count_o), 32'(m_frame.size()));
    chk("done", 32'(done_o), 32'(m_full));
    chk("busy", 32'(busy_o), 32'(!m_full && m_frame.size() > 0));
    chk("match", 32'(match_o), 32'(m_match));
  endtask

  // One clock of stimulus; the model predicts what that edge must produce.
  task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit r, input bit rs);
    bit         acc;
    bit         e_err;
    bit         e_rd;
    logic [7:0] e_data;
    we_i = w; addr_i = a; data_i = d; rd_en_i = r; rst = rs;
    acc = w && (a == ADDR) && (d[7:0] != 8'h00);
    e_err = 1'b0; e_rd = 1'b0; e_data = 8'h00;
    if (rs) begin
      m_frame.delete(); m_full = 1'b0; m_idle = 0; m_match = 1'b0;
    end else if (m_full) begin
      if (acc) e_err = 1'b1;
      if (r) begin
        e_rd = 1'b1;
        e_data = m_frame.pop_front();
        if (m_frame.size() == 0) begin m_full = 1'b0; m_match = 1'b0; end
      end
    end else if (acc) begin
      m_frame.push_back(d[7:0]);
      m_idle = 0;
      if (m_frame.size() == DEPTH) begin m_full = 1'b1; m_match = frame_is_id(); end
    end else if (m_frame.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin e_err = 1'b1; m_frame.delete(); m_idle = 0; end
    end
    @(posedge clk); #1;
    if (e_err) err_q.push_back(edge_n);
    if (e_rd) exp_q.push_back(e_data);
    check_status();
  endtask

  task automatic wr(input logic [7:0] b);
    logic [31:0] t;
    t = $urandom();
    step(1'b1, ADDR, {t[31:8], b}, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Monitor: every read-back byte and error pulse must match the queues.
  always @(negedge clk) begin
    logic [7:0] e;
    int         t;
    if (rd_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %0h exp none at edge %0d", rd_data_o, edge_n);
      end else begin
        e = exp_q.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL rd_data got %0h exp %0h at edge %0d", rd_data_o, e, edge_n);
        end
      end
    end
    if (err_o) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected got pulse exp none at edge %0d", edge_n);
      end else begin
        t = err_q.pop_front();
        if (t != edge_n) begin
          errors++;
          $display("FAIL err_timing got edge %0d exp edge %0d", edge_n, t);
        end
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] t;
    bit          w;
    bit          r;
    logic [31:0] a;

    // Reset state.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("rst_rd_data", 32'(rd_data_o), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Matching frame back-to-back, then back-to-back pops.
    for (int i = 0; i < DEPTH; i++) wr(id_str[i]);
    for (int i = 0; i < DEPTH; i++) pop();
    idle(2);

    // Frame with one wrong byte; pops with gaps; early rd_en ignored.
    pop();
    for (int i = 0; i < DEPTH; i++) begin
      wr((i == 5) ? 8'h34 : id_str[i]);
      if (i == 3) pop();
    end
    for (int i = 0; i < DEPTH; i++) begin pop(); idle(i % 3); end
    pop();

    // Three bytes then idle into timeout.
    for (int i = 0; i < 3; i++) wr(id_str[i]);
    idle(TIMEOUT);
    idle(2);

    // Byte arriving on the cycle the timeout would fire wins.
    wr(8'h55);
    idle(TIMEOUT - 1);
    wr(8'h66);
    idle(TIMEOUT - 1);
    wr(8'h77);
    idle(TIMEOUT + 1);

    // Ignored writes interleaved with a valid frame.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, ADDR + 32'd4, 32'h0000_0011, 1'b0, 1'b0);
      step(1'b1, ADDR, 32'h1234_5600, 1'b0, 1'b0);
      wr(id_str[i]);
    end

    // Extra write while held, four pops, then reset mid-readout.
    wr(8'h41);
    wr(8'h42);
    for (int i = 0; i < 4; i++) pop();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("rst_mid_rd_data", 32'(rd_data_o), 32'h0);
    chk("rst_mid_rd_valid", 32'(rd_valid_o), 32'h0);
    chk("rst_mid_err", 32'(err_o), 32'h0);

    // Reset mid-frame, then a fresh frame is captured from index 0.
    for (int i = 0; i < 4; i++) wr(8'h99);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) wr(id_str[i]);
    for (int i = 0; i < DEPTH; i++) pop();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
      end else begin
        w = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 7) == 0) ? ADDR + 32'd4 : ADDR;
        if ($urandom_range(0, 7) == 0) b = 8'h00;
        else if ($urandom_range(0, 1) == 0 && m_frame.size() < DEPTH) b = id_str[m_frame.size()];
        else b = 8'($urandom_range(1, 255));
        t = $urandom();
        r = ($urandom_range(0, 2) == 0);
        step(w, a, {t[31:8], b}, r, ($urandom_range(0, 499) == 0));
      end
    end
    idle(3);

    chk("rd_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("err_queue_drained", 32'(err_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_rx.md
SID_RX -- requirements
Module: sid_rx

Interface
REQ-001: Parameter DEPTH, 10, number of ID bytes per frame (2..15).
REQ-002: Parameter ADDR, 32'h3000_0000, UART write address the block listens on.
REQ-003: Parameter TIMEOUT, 64, max idle cycles allowed between bytes inside a frame (1..255).
REQ-004: clk  in  1  single clock; all logic on rising edge.
REQ-005: rst  in  1  reset, synchronous, active-high.
REQ-006: we_i  in  1  bus write strobe.
REQ-007: addr_i  in  32  bus write address.
REQ-008: data_i  in  32  bus write data; only [7:0] used.
REQ-009: rd_en_i  in  1  pop one captured byte.
REQ-010: rd_data_o  out  8  popped byte, registered.
REQ-011: rd_valid_o  out  1  one-cycle pulse, rd_data_o valid.
REQ-012: busy_o  out  1  frame reception in progress.
REQ-013: done_o  out  1  full frame captured, buffer holds DEPTH bytes.
REQ-014: match_o  out  1  captured frame equals expected ID (see Configuration).
REQ-015: err_o  out  1  one-cycle pulse on timeout or write-while-DONE.
REQ-016: count_o  out  4  bytes currently held in buffer.

Function
REQ-017: Accepted byte = cycle with we_i=1, addr_i==ADDR, data_i[7:0]!=0; all other cycles ignored, including zero-data writes to ADDR.
REQ-018: FSM states IDLE, RECV, DONE.
REQ-019: IDLE: accepted byte -> store at index 0, count_o=1, go RECV next cycle.
REQ-020: RECV: each accepted byte stored at index count_o, count_o increments; byte DEPTH stored -> DONE next cycle, done_o=1 same edge.
REQ-021: RECV: idle counter reloads on each accepted byte; TIMEOUT consecutive cycles without one -> err_o pulse, buffer cleared (count_o=0), go IDLE.
REQ-022: Back-to-back accepted bytes every cycle SHALL all be captured (one per cycle, no stall).
REQ-023: DONE: accepted bytes discarded, each discarded byte pulses err_o; buffer and match_o unchanged.
REQ-024: DONE: rd_en_i=1 -> rd_data_o = next unread byte in arrival order, rd_valid_o=1 next cycle, count_o decrements.
REQ-025: rd_en_i outside DONE or with count_o=0 SHALL be ignored, rd_valid_o stays 0.
REQ-026: Last byte popped -> go IDLE, done_o=0, match_o=0 same edge.
REQ-027: busy_o = (state==RECV), combinational from state.
REQ-028: Timeout and accepted byte in same cycle: byte wins, no err_o.

Reset
REQ-029: rst=1 at any clock edge, including mid-frame or mid-readout: state IDLE, count_o=0, idle counter 0, read pointer 0.
REQ-030: Reset values: rd_data_o=0, rd_valid_o=0, busy_o=0, done_o=0, match_o=0, err_o=0; buffer contents need not be cleared.

Configuration
REQ-031: Macro SID_RX_CMP_EN defined: match flag cleared on frame start, ANDed per byte with (byte == expected[index]), expected = ASCII "2023310655" (8'h32,30,32,33,33,31,30,36,35,35) for DEPTH=10; match_o = flag while DONE.
REQ-032: Macro SID_RX_CMP_EN undefined: no comparison logic, match_o tied 0; all other behaviour identical.

Verification
REQ-033: Ten accepted writes 8'h32,30,32,33,33,31,30,36,35,35 on consecutive cycles -> done_o=1 after 10th edge, count_o=10, match_o=1 (0 without SID_RX_CMP_EN).
REQ-034: Same frame with byte 5 = 8'h34 -> done_o=1, match_o=0; ten rd_en_i pulses return bytes in order, then IDLE.
REQ-035: Three bytes then 64 idle cycles -> err_o pulse on 64th cycle, count_o=0, busy_o=0.
REQ-036: Writes to ADDR+4 and zero-data writes to ADDR interleaved with a valid frame -> ignored, frame still matches.
REQ-037: Extra write during DONE -> err_o pulse, count_o stays 10; rst asserted after 4 pops -> all outputs at reset values next cycle.
